// File: rtl/deskew_reg_block.sv
// Register block for the deskew engine: configuration storage, start/soft-reset
// pulses, sticky status flags with software clear, and a 1-cycle-latency read port.
module deskew_reg_block (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_reg,
    input  logic        write_reg,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    input  logic [7:0]  reg_raddr,
    input  logic [7:0]  reg_waddr,
    input  logic        mem_acc_err,
    input  logic        err_size,
    input  logic        done,
    input  logic        idle,
    output logic        mem_acc_err_ack,
    output logic        err_size_ack,
    output logic        done_ack,
    output logic [8:0]  img_w_l,
    output logic [16:0] start_addr_in,
    output logic [16:0] start_addr_out,
    output logic        start_deskew,
    output logic        soft_rst
);

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_IMG      = 8'h04;
    localparam logic [7:0] ADDR_ADDR_IN  = 8'h08;
    localparam logic [7:0] ADDR_STAT     = 8'h0C;
    localparam logic [7:0] ADDR_ACK      = 8'h10;
    localparam logic [7:0] ADDR_ADDR_OUT = 8'h14;

    logic [8:0]  img_w_l_q,   img_w_l_d;
    logic [16:0] addr_in_q,   addr_in_d;
    logic [16:0] addr_out_q,  addr_out_d;
    logic        start_q,     start_d;
    logic        soft_rst_q,  soft_rst_d;
    logic [2:0]  ack_q,       ack_d;
    logic [2:0]  sticky_q,    sticky_d;
    logic [31:0] rdata_q,     rdata_d;

    logic       wr_ctrl;
    logic       wr_ack;
    logic [2:0] status_in;

    assign wr_ctrl   = write_reg && (reg_waddr == ADDR_CTRL);
    assign wr_ack    = write_reg && (reg_waddr == ADDR_ACK);
    assign status_in = {done, err_size, mem_acc_err};

    always_comb begin
        img_w_l_d  = img_w_l_q;
        addr_in_d  = addr_in_q;
        addr_out_d = addr_out_q;
        start_d    = wr_ctrl && reg_wdata[0];
        soft_rst_d = wr_ctrl && reg_wdata[1];
        ack_d      = wr_ack ? reg_wdata[2:0] : 3'b000;

        if (write_reg) begin
            case (reg_waddr)
                ADDR_IMG:      img_w_l_d  = reg_wdata[8:0];
                ADDR_ADDR_IN:  addr_in_d  = reg_wdata[16:0];
                ADDR_ADDR_OUT: addr_out_d = reg_wdata[16:0];
                default: ;
            endcase
        end

        // A clear wins over a same-cycle set; a still-high input re-sets next cycle.
        for (int i = 0; i < 3; i++) begin
            if (wr_ack && reg_wdata[i]) begin
                sticky_d[i] = 1'b0;
            end else begin
                sticky_d[i] = sticky_q[i] | status_in[i];
            end
        end

        rdata_d = rdata_q;
        if (read_reg) begin
            case (reg_raddr)
                ADDR_IMG:      rdata_d = {23'd0, img_w_l_q};
                ADDR_ADDR_IN:  rdata_d = {15'd0, addr_in_q};
                ADDR_STAT:     rdata_d = {28'd0, idle, sticky_q};
                ADDR_ADDR_OUT: rdata_d = {15'd0, addr_out_q};
                default:       rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_w_l_q  <= '0;
            addr_in_q  <= '0;
            addr_out_q <= '0;
            start_q    <= 1'b0;
            soft_rst_q <= 1'b0;
            ack_q      <= '0;
            sticky_q   <= '0;
            rdata_q    <= '0;
        end else begin
            img_w_l_q  <= img_w_l_d;
            addr_in_q  <= addr_in_d;
            addr_out_q <= addr_out_d;
            start_q    <= start_d;
            soft_rst_q <= soft_rst_d;
            ack_q      <= ack_d;
            sticky_q   <= sticky_d;
            rdata_q    <= rdata_d;
        end
    end

    assign reg_rdata       = rdata_q;
    assign img_w_l         = img_w_l_q;
    assign start_addr_in   = addr_in_q;
    assign start_addr_out  = addr_out_q;
    assign start_deskew    = start_q;
    assign soft_rst        = soft_rst_q;
    assign mem_acc_err_ack = ack_q[0];
    assign err_size_ack    = ack_q[1];
    assign done_ack        = ack_q[2];

endmodule

// File: tb/tb_deskew_reg_block.sv
// Directed bench for deskew_reg_block: read expectations go through a queue
// and are compared one cycle after the read strobe.
module tb_deskew_reg_block;

    logic        clk;
    logic        rst_n;
    logic        read_reg;
    logic        write_reg;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [7:0]  reg_raddr;
    logic [7:0]  reg_waddr;
    logic        mem_acc_err;
    logic        err_size;
    logic        done;
    logic        idle;
    logic        mem_acc_err_ack;
    logic        err_size_ack;
    logic        done_ack;
    logic [8:0]  img_w_l;
    logic [16:0] start_addr_in;
    logic [16:0] start_addr_out;
    logic        start_deskew;
    logic        soft_rst;

    int          passCount;
    int          totalCount;
    logic [31:0] expQueue[$];

    deskew_reg_block dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_reg        (read_reg),
        .write_reg       (write_reg),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .reg_raddr       (reg_raddr),
        .reg_waddr       (reg_waddr),
        .mem_acc_err     (mem_acc_err),
        .err_size        (err_size),
        .done            (done),
        .idle            (idle),
        .mem_acc_err_ack (mem_acc_err_ack),
        .err_size_ack    (err_size_ack),
        .done_ack        (done_ack),
        .img_w_l         (img_w_l),
        .start_addr_in   (start_addr_in),
        .start_addr_out  (start_addr_out),
        .start_deskew    (start_deskew),
        .soft_rst        (soft_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] waddr, input logic [31:0] wdata,
                                 input logic rd, input logic [7:0] raddr, input logic [31:0] rexp);
        write_reg = wr;
        reg_waddr = waddr;
        reg_wdata = wdata;
        read_reg  = rd;
        reg_raddr = raddr;
        if (rd) expQueue.push_back(rexp);
    endtask

    task automatic stepCycle();
        logic        wasRead;
        logic [31:0] expVal;
        wasRead = read_reg;
        @(posedge clk);
        #1;
        write_reg = 1'b0;
        read_reg  = 1'b0;
        if (wasRead) begin
            if (expQueue.size() == 0) begin
                checkOutput("queue_underflow", 32'd1, 32'd0);
            end else begin
                expVal = expQueue.pop_front();
                checkOutput("rdata", reg_rdata, expVal);
            end
        end
    endtask

    initial begin
        logic [7:0]  rstAddrs [4];
        logic [31:0] sweepExp;

        passCount   = 0;
        totalCount  = 0;
        rst_n       = 1'b0;
        read_reg    = 1'b0;
        write_reg   = 1'b0;
        reg_wdata   = '0;
        reg_raddr   = '0;
        reg_waddr   = '0;
        mem_acc_err = 1'b0;
        err_size    = 1'b0;
        done        = 1'b0;
        idle        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdata", reg_rdata, 32'd0);
        checkOutput("reset_cfg", {img_w_l, start_addr_in, start_addr_out}, 32'd0);
        checkOutput("reset_pulses",
                    {27'd0, start_deskew, soft_rst, mem_acc_err_ack, err_size_ack, done_ack}, 32'd0);
        rst_n = 1'b1;

        // Every readable register comes up zero
        rstAddrs = '{8'h04, 8'h08, 8'h0C, 8'h14};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, rstAddrs[i], 32'd0);
            stepCycle();
        end

        // CTRL write fires both pulses for one cycle; CTRL reads as zero
        applyStimulus(1'b1, 8'h00, 32'h3, 1'b1, 8'h00, 32'd0);
        stepCycle();
        checkOutput("pulse_high", {30'd0, start_deskew, soft_rst}, 32'h3);
        stepCycle();
        checkOutput("pulse_low", {30'd0, start_deskew, soft_rst}, 32'h0);

        // Config writes, back-to-back, with upper bits discarded
        applyStimulus(1'b1, 8'h04, 32'hFFFF_FFFF, 1'b0, 8'h00, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 8'h08, 32'h0001_ABCD, 1'b0, 8'h00, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 8'h14, 32'h0003_FFFF, 1'b0, 8'h00, 32'd0);
        stepCycle();
        checkOutput("img_w_l", {23'd0, img_w_l}, 32'h1FF);
        checkOutput("start_addr_in", {15'd0, start_addr_in}, 32'h1ABCD);
        checkOutput("start_addr_out", {15'd0, start_addr_out}, 32'h1FFFF);

        // A write to an unaligned address leaves the config untouched
        applyStimulus(1'b1, 8'h05, 32'h0000_0000, 1'b0, 8'h00, 32'd0);
        stepCycle();
        checkOutput("unaligned_write", {23'd0, img_w_l}, 32'h1FF);

        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h05, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h04, 32'h1FF);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h08, 32'h1ABCD);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h14, 32'h1FFFF);
        stepCycle();
        stepCycle();
        checkOutput("rdata_hold", reg_rdata, 32'h1FFFF);

        // Sticky flags latch a one-cycle pulse and clear on ACK
        mem_acc_err = 1'b1;
        err_size    = 1'b1;
        done        = 1'b1;
        stepCycle();
        mem_acc_err = 1'b0;
        err_size    = 1'b0;
        done        = 1'b0;
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h0C, 32'h7);
        stepCycle();
        applyStimulus(1'b1, 8'h10, 32'h0000_00FF, 1'b0, 8'h00, 32'd0);
        stepCycle();
        checkOutput("ack_high", {29'd0, done_ack, err_size_ack, mem_acc_err_ack}, 32'h7);
        stepCycle();
        checkOutput("ack_low", {29'd0, done_ack, err_size_ack, mem_acc_err_ack}, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h0C, 32'h0);
        stepCycle();

        // Clear beats a simultaneous set; the still-high input sets again afterwards
        done = 1'b1;
        stepCycle();
        applyStimulus(1'b1, 8'h10, 32'h4, 1'b0, 8'h00, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h0C, 32'h0);
        stepCycle();
        done = 1'b0;
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h0C, 32'h4);
        stepCycle();
        applyStimulus(1'b1, 8'h10, 32'h4, 1'b0, 8'h00, 32'd0);
        stepCycle();

        // Same-cycle read and write of one register returns the old value
        applyStimulus(1'b1, 8'h04, 32'h55, 1'b1, 8'h04, 32'h1FF);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h04, 32'h55);
        stepCycle();

        // IDLE is a live level, not sticky
        idle = 1'b1;
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h0C, 32'h8);
        stepCycle();
        idle = 1'b0;
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'h0C, 32'h0);
        stepCycle();

        // Back-to-back sweep over 0x00-0x0F
        idle = 1'b1;
        for (int a = 0; a < 16; a++) begin
            case (a)
                4:       sweepExp = 32'h55;
                8:       sweepExp = 32'h1ABCD;
                12:      sweepExp = 32'h8;
                default: sweepExp = 32'h0;
            endcase
            applyStimulus(1'b0, 8'h00, 32'd0, 1'b1, 8'(a), sweepExp);
            stepCycle();
        end
        idle = 1'b0;

        checkOutput("queue_empty", expQueue.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/deskew_reg_block.md
Name: deskew_reg_block

Overview:
- Register block for the deskew engine.
- Sits between the AXI-to-register bridge (simple read/write strobes with byte addresses) and the deskew controller.
- Holds configuration (image size, source and destination addresses), generates the start and soft-reset pulses, latches sticky status flags, and produces acknowledge pulses when software clears those flags.

Parameters:
- None. Widths are fixed as listed under Ports.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- read_reg  in  1  read strobe, one cycle per access.
- write_reg  in  1  write strobe, one cycle per access.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  registered read data.
- reg_raddr  in  8  read byte address.
- reg_waddr  in  8  write byte address.
- mem_acc_err  in  1  controller memory-access error (level).
- err_size  in  1  controller image-size error (level).
- done  in  1  controller job done (level).
- idle  in  1  controller idle (level).
- mem_acc_err_ack  out  1  clear pulse to the controller.
- err_size_ack  out  1  clear pulse to the controller.
- done_ack  out  1  clear pulse to the controller.
- img_w_l  out  9  image width/length configuration.
- start_addr_in  out  17  source buffer start address.
- start_addr_out  out  17  destination buffer start address.
- start_deskew  out  1  start pulse.
- soft_rst  out  1  soft-reset pulse.

Behaviour:
- Reset: rst_n low asynchronously clears every register and output to 0, including reg_rdata, all pulses and all sticky flags.
- Address decode: exact byte-address match only. Unaligned or unmapped addresses (e.g. 0x05, 0x01) read as 0 and ignore writes.
- Register map:
  - 0x00 DSQW_CTRL (W): bit0 START, bit1 SOFT_RST. Reads as 0.
  - 0x04 DSQW_IMG (R/W): bits[8:0] img_w_l.
  - 0x08 DSQW_ADDR_IN (R/W): bits[16:0] start_addr_in.
  - 0x0C DSQW_STAT (R): bit0 MEM_ACC_ERR, bit1 ERR_SIZE, bit2 DONE, bit3 IDLE. Writes are ignored.
  - 0x10 DSQW_ACK (W): bit0 clears MEM_ACC_ERR, bit1 clears ERR_SIZE, bit2 clears DONE. Reads as 0.
  - 0x14 DSQW_ADDR_OUT (R/W): bits[16:0] start_addr_out.
- Writes: take effect at the rising edge where write_reg=1.
  - Config registers store the low bits of reg_wdata; upper bits are discarded and read back as 0.
  - Back-to-back writes every cycle are supported.
- Pulses:
  - A CTRL write with bit0=1 drives start_deskew high for exactly one cycle, starting the cycle after the write edge. A CTRL write with bit1=1 does the same for soft_rst. Both may fire together.
  - An ACK write with bit n=1 drives the matching *_ack output high for exactly one cycle with the same timing.
  - Bits of ACK above bit2 are ignored.
  - soft_rst is only an output; it does not clear this block's registers.
- Sticky status:
  - Each of MEM_ACC_ERR, ERR_SIZE and DONE is set on any clock where its input is 1, and held until cleared by an ACK write.
  - Clear has priority when a clear and a set happen in the same cycle. If the input is still high, the flag sets again on the following cycle.
  - IDLE is not sticky: STAT bit3 reflects the idle input sampled on the read edge.
- Reads:
  - reg_rdata is updated at the rising edge where read_reg=1 and is valid the following cycle (1-cycle latency).
  - reg_rdata holds its value while read_reg=0.
  - Back-to-back reads every cycle are supported.
- Same-cycle read and write to the same address: the read returns the pre-write value.

Test Plan:
- Reset, then read 0x04, 0x08, 0x0C and 0x14 -> all return 0; every output is 0.
- Write 0x00 with 0x3 -> start_deskew and soft_rst each high for exactly one cycle after the write edge; a read of 0x00 returns 0.
- Write 0x04 with 0xFFFFFFFF, 0x08 with 0x1ABCD and 0x14 with 0x3FFFF, then read each back -> img_w_l=0x1FF with read 0x1FF; start_addr_in=0x1ABCD; start_addr_out=0x1FFFF. The read of 0x05 returns 0.
- With mem_acc_err=err_size=done=1 and idle=0 for one cycle, read 0x0C -> 0x7. Write 0x10 with 0xFF -> each *_ack pulses for one cycle. Next read of 0x0C -> 0x0 (inputs dropped).
- Set idle=1 and read 0x0C -> bit3=1. Drop idle and read again -> bit3=0.
- Continuous read of addresses 0x00-0x0F, one per cycle -> data appears one cycle after each address; only 0x04, 0x08 and 0x0C return nonzero (after setup).
